// File: rtl/tube_pkg.sv
// tube_pkg: shared constants for the seven-segment tube responder.
//   - register offsets on the tube IO window
//   - active-high segment patterns for hex digits 0..F (bit 0 = a .. bit 6 = g)
//   - blank code driven on the active-low segment lines when a digit is off
package tube_pkg;

    localparam logic [1:0] TUBE_OFF_VALUE = 2'd0;
    localparam logic [1:0] TUBE_OFF_BLANK = 2'd1;
    localparam logic [1:0] TUBE_OFF_DP    = 2'd2;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;
    localparam logic [6:0] SEG_PAT_A = 7'h77;
    localparam logic [6:0] SEG_PAT_B = 7'h7C;
    localparam logic [6:0] SEG_PAT_C = 7'h39;
    localparam logic [6:0] SEG_PAT_D = 7'h5E;
    localparam logic [6:0] SEG_PAT_E = 7'h79;
    localparam logic [6:0] SEG_PAT_F = 7'h71;

    // All segments and the decimal point off (active-low lines).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-high pattern for one hex nibble.
    function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = SEG_PAT_0;
            4'h1:    pat = SEG_PAT_1;
            4'h2:    pat = SEG_PAT_2;
            4'h3:    pat = SEG_PAT_3;
            4'h4:    pat = SEG_PAT_4;
            4'h5:    pat = SEG_PAT_5;
            4'h6:    pat = SEG_PAT_6;
            4'h7:    pat = SEG_PAT_7;
            4'h8:    pat = SEG_PAT_8;
            4'h9:    pat = SEG_PAT_9;
            4'hA:    pat = SEG_PAT_A;
            4'hB:    pat = SEG_PAT_B;
            4'hC:    pat = SEG_PAT_C;
            4'hD:    pat = SEG_PAT_D;
            4'hE:    pat = SEG_PAT_E;
            default: pat = SEG_PAT_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment decoder.
//   nibble_i  [3:0] : hex digit to display
//   seg_n_o   [6:0] : active-low segments a..g (bit 0 = a)
module hex_to_seg
    import tube_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = ~seg_pattern(nibble_i);
    end

endmodule

// File: rtl/tube_io.sv
// tube_io: memory-mapped 8-digit seven-segment display responder.
//   clock            : system clock, rising edge
//   reset_n          : asynchronous active-low reset
//   tube_ctrl        : tube chip select; every high cycle is one write
//   tube_addr  [1:0] : 0 = value, 1 = blank mask, 2 = dp mask, 3 = reserved
//   tube_wdata [31:0]: write data
//   seg_en     [7:0] : active-low digit enables, bit 0 = rightmost digit
//   seg_out    [7:0] : active-low segments, bits 0..6 = a..g, bit 7 = dp
// Bus handshake: none. There is no ready/back-pressure; a write is taken on
// every rising edge where tube_ctrl is high.
module tube_io
    import tube_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tube_ctrl,
    input  logic [1:0]  tube_addr,
    input  logic [31:0] tube_wdata,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [31:0]      value_q, value_d;
    logic [7:0]       blank_q, blank_d;
    logic [7:0]       dp_q, dp_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       seg_en_q, seg_en_d;
    logic [7:0]       seg_out_q, seg_out_d;

    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg_n;

    // Register write decode; reserved offset leaves everything untouched.
    always_comb begin
        value_d = value_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        if (tube_ctrl) begin
            case (tube_addr)
                TUBE_OFF_VALUE: value_d = tube_wdata;
                TUBE_OFF_BLANK: blank_d = tube_wdata[7:0];
                TUBE_OFF_DP:    dp_d    = tube_wdata[7:0];
                default:        ;
            endcase
        end
    end

    // Scan divider and digit index; idx wraps 7 -> 0 naturally in 3 bits.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end
    end

    assign cur_nibble = value_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (cur_nibble),
        .seg_n_o  (cur_seg_n)
    );

    // Enable and segments come from the same idx_q, so both output
    // registers always agree on which digit is being driven.
    always_comb begin
        seg_en_d = ~(8'd1 << idx_q);
        if (blank_q[idx_q]) begin
            seg_out_d = SEG_BLANK;
        end else begin
            seg_out_d = {~dp_q[idx_q], cur_seg_n};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q   <= '0;
            blank_q   <= '0;
            dp_q      <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            seg_en_q  <= 8'hFF;
            seg_out_q <= SEG_BLANK;
        end else begin
            value_q   <= value_d;
            blank_q   <= blank_d;
            dp_q      <= dp_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_tube_io.sv
module tb_tube_io;

    localparam int SD = 4;

    logic        clock;
    logic        reset_n;
    logic        tube_ctrl;
    logic [1:0]  tube_addr;
    logic [31:0] tube_wdata;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];

    // Reference model state
    logic [31:0] m_value;
    logic [7:0]  m_blank;
    logic [7:0]  m_dp;
    int          m_div;
    int          m_idx;

    logic [7:0]  frame[8];

    tube_io #(.SCAN_DIV(SD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tube_ctrl  (tube_ctrl),
        .tube_addr  (tube_addr),
        .tube_wdata (tube_wdata),
        .seg_en     (seg_en),
        .seg_out    (seg_out)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] tb_pat(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return p;
    endfunction

    function automatic logic [15:0] model_out();
        logic [7:0] en;
        logic [7:0] so;
        logic [3:0] nib;
        en  = 8'hFF;
        en[m_idx] = 1'b0;
        nib = 4'((m_value >> (4 * m_idx)) & 32'hF);
        if (m_blank[m_idx]) so = 8'hFF;
        else                so = {~m_dp[m_idx], ~tb_pat(nib)};
        return {en, so};
    endfunction

    function automatic logic [7:0] dig_code(input int d);
        logic [7:0] c;
        c = 8'hFF;
        c[d] = 1'b0;
        return c;
    endfunction

    task automatic model_reset();
        m_value = '0;
        m_blank = '0;
        m_dp    = '0;
        m_div   = 0;
        m_idx   = 0;
    endtask

    // One clock: push expected output for this edge, advance the model with
    // the inputs seen at the edge, then compare the DUT output after it.
    task automatic step();
        logic        c;
        logic [1:0]  a;
        logic [31:0] w;
        logic        rn;
        c  = tube_ctrl;
        a  = tube_addr;
        w  = tube_wdata;
        rn = reset_n;
        exp_q.push_back(rn ? model_out() : 16'hFFFF);
        @(posedge clock);
        if (rn) begin
            if (c) begin
                if (a == 2'd0)      m_value = w;
                else if (a == 2'd1) m_blank = w[7:0];
                else if (a == 2'd2) m_dp    = w[7:0];
            end
            if (m_div == SD - 1) begin
                m_div = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_div = m_div + 1;
            end
        end
        #1;
        check("scoreboard", {16'h0, seg_en, seg_out}, {16'h0, exp_q.pop_front()});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [1:0] a, input logic [31:0] w);
        tube_ctrl  = 1'b1;
        tube_addr  = a;
        tube_wdata = w;
        step();
        tube_ctrl  = 1'b0;
        tube_wdata = $urandom;
    endtask

    // Advance to the first cycle on which digit d becomes enabled.
    task automatic wait_digit(input int d);
        int n;
        n = 0;
        while (seg_en == dig_code(d) && n < 64) begin step(); n++; end
        n = 0;
        while (seg_en != dig_code(d) && n < 64) begin step(); n++; end
        check($sformatf("sync_d%0d", d), {24'h0, seg_en}, {24'h0, dig_code(d)});
    endtask

    // From the first cycle of digit 0, walk one frame: record each digit's
    // first segment value and check each digit dwells exactly SD cycles.
    task automatic count_frame();
        int cnt;
        for (int d = 0; d < 8; d++) begin
            cnt = 0;
            frame[d] = seg_out;
            while (seg_en == dig_code(d) && cnt < 16) begin step(); cnt++; end
            check($sformatf("dwell_d%0d", d), cnt, SD);
        end
    endtask

    task automatic check_blank_dp_frame(input string pfx);
        check({pfx, "_d0"}, frame[0], 8'h40);
        check({pfx, "_d1"}, frame[1], 8'hC0);
        check({pfx, "_d2"}, frame[2], 8'hC0);
        check({pfx, "_d3"}, frame[3], 8'hC0);
        for (int d = 4; d < 8; d++) check($sformatf("%s_d%0d", pfx, d), frame[d], 8'hFF);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset_n    = 1'b0;
        tube_ctrl  = 1'b0;
        tube_addr  = 2'd0;
        tube_wdata = '0;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_first", {16'h0, seg_en, seg_out}, 32'h0000FEC0);

        // Reset asserted mid-frame
        repeat (10) step();
        reset_n = 1'b0;
        #2;
        check("rst_async_en", {24'h0, seg_en}, 32'hFF);
        check("rst_async_out", {24'h0, seg_out}, 32'hFF);
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("rst_restart", {16'h0, seg_en, seg_out}, 32'h0000FEC0);
        count_frame();

        // Value 0x12345678 over one frame
        do_write(2'd0, 32'h12345678);
        wait_digit(0);
        count_frame();
        check("v1_d0", frame[0], 8'h80);
        check("v1_d3", frame[3], 8'h92);
        check("v1_d7", frame[7], 8'hF9);

        // Write landing while digit 0 is active
        step();
        do_write(2'd0, 32'hDEADBEEF);
        check("live_old", {24'h0, seg_out}, 32'h80);
        step();
        check("live_new", {16'h0, seg_en, seg_out}, 32'h0000FE8E);
        wait_digit(6);
        check("v2_d6", {24'h0, seg_out}, 32'h86);

        // Blank and dp masks, upper data bits ignored
        do_write(2'd0, 32'h00000000);
        do_write(2'd1, 32'hABCDEFF0);
        do_write(2'd2, 32'hFFFFFF11);
        wait_digit(0);
        count_frame();
        check_blank_dp_frame("mask");

        // Reserved offset: no change
        do_write(2'd3, 32'hFFFFFFFF);
        wait_digit(0);
        count_frame();
        check_blank_dp_frame("rsvd");

        // Write on the idx 7 -> 0 wrap edge
        do_write(2'd1, 32'h0);
        do_write(2'd2, 32'h0);
        n = 0;
        while (!(m_idx == 7 && m_div == SD - 1) && n < 64) begin step(); n++; end
        check("wrap_sync", m_idx * 16 + m_div, 7 * 16 + SD - 1);
        do_write(2'd0, 32'h0000000A);
        step();
        check("wrap_new", {16'h0, seg_en, seg_out}, 32'h0000FE88);
        count_frame();

        // Random traffic, checked by the scoreboard every cycle
        for (int i = 0; i < 120; i++) begin
            tube_ctrl  = ($urandom_range(0, 3) == 0);
            tube_addr  = 2'($urandom_range(0, 3));
            tube_wdata = $urandom;
            step();
        end
        tube_ctrl = 1'b0;
        repeat (2 * 8 * SD) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
